// File: rtl/stepper_phase_decoder.sv
// -----------------------------------------------------------------------------
// stepper_phase_decoder
//   Monitor-side decoder for a 4-phase one-hot stepper coil bus. It recovers the
//   step direction and a wrapping signed position count. It flags illegal phase
//   patterns (multi-hot, opposite coil or skipped step) and stalls.
//
//   Ports
//     clk        : rising-edge clock
//     rst        : synchronous active-high reset
//     phase[3:0] : coil phase bus, forward order 1000->0100->0010->0001->1000
//     pos        : position count, +1 forward / -1 reverse, wraps mod 2^POS_W
//     dir        : direction of last accepted step (1 = forward)
//     step_pulse : one-cycle pulse per accepted step
//     locked     : tracking a valid phase sequence
//     err        : illegal phase pattern seen; held until the bus returns to 0000
//     stalled    : locked with no step for at least STALL_CYCLES cycles
//
//   The phase bus is registered once before any decision is made, so an input
//   change shows up on the outputs two rising edges later.
// -----------------------------------------------------------------------------
module stepper_phase_decoder #(
   parameter int POS_W        = 8,
   parameter int STALL_CYCLES = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       phase,
   output logic [POS_W-1:0] pos,
   output logic             dir,
   output logic             step_pulse,
   output logic             locked,
   output logic             err,
   output logic             stalled
);

   localparam int CNT_W = $clog2(STALL_CYCLES + 1);
   localparam logic [CNT_W-1:0] STALL_MAX = CNT_W'(STALL_CYCLES);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOCKED = 2'd1,
      FAULT  = 2'd2
   } state_t;

   state_t           state;
   logic [3:0]       phase_q;
   logic [3:0]       prev;
   logic [CNT_W-1:0] stall_cnt;

   // Forward is a rotate right of the one-hot pattern; reverse is a rotate left.
   function automatic logic [3:0] fwd(input logic [3:0] p);
      return {p[0], p[3:1]};
   endfunction

   function automatic logic [3:0] rev(input logic [3:0] p);
      return {p[2:0], p[3]};
   endfunction

   function automatic logic onehot(input logic [3:0] p);
      return (p != 4'b0000) && ((p & (p - 4'd1)) == 4'b0000);
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         // Any phase sample in flight is dropped along with the rest of the state.
         phase_q    <= 4'b0000;
         prev       <= 4'b0000;
         state      <= IDLE;
         pos        <= '0;
         dir        <= 1'b1;
         step_pulse <= 1'b0;
         locked     <= 1'b0;
         err        <= 1'b0;
         stall_cnt  <= '0;
      end else begin
         phase_q    <= phase;
         step_pulse <= 1'b0;
         case (state)
            IDLE: begin
               if (phase_q == 4'b0000) begin
                  state <= IDLE;
               end else if (onehot(phase_q)) begin
                  // The first valid coil only sets the reference. No step is counted.
                  state     <= LOCKED;
                  locked    <= 1'b1;
                  prev      <= phase_q;
                  stall_cnt <= '0;
               end else begin
                  state <= FAULT;
                  err   <= 1'b1;
               end
            end
            LOCKED: begin
               if (phase_q == prev) begin
                  if (stall_cnt < STALL_MAX) stall_cnt <= stall_cnt + 1'b1;
               end else if (phase_q == fwd(prev)) begin
                  pos        <= pos + 1'b1;
                  dir        <= 1'b1;
                  step_pulse <= 1'b1;
                  prev       <= phase_q;
                  stall_cnt  <= '0;
               end else if (phase_q == rev(prev)) begin
                  pos        <= pos - 1'b1;
                  dir        <= 1'b0;
                  step_pulse <= 1'b1;
                  prev       <= phase_q;
                  stall_cnt  <= '0;
               end else if (phase_q == 4'b0000) begin
                  // The driver has gone back to reset. Relock on the next valid coil.
                  state     <= IDLE;
                  locked    <= 1'b0;
                  stall_cnt <= '0;
               end else begin
                  // Opposite coil or multi-hot: a skipped step or a bus fault.
                  state     <= FAULT;
                  locked    <= 1'b0;
                  err       <= 1'b1;
                  stall_cnt <= '0;
               end
            end
            FAULT: begin
               if (phase_q == 4'b0000) begin
                  state <= IDLE;
                  err   <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               locked    <= 1'b0;
               err       <= 1'b0;
               stall_cnt <= '0;
            end
         endcase
      end
   end

   // stall_cnt is held at zero outside LOCKED, so stalled drops on a step
   // and whenever the decoder leaves LOCKED.
   assign stalled = locked && (stall_cnt >= STALL_MAX);

endmodule

// File: tb/tb_stepper_phase_decoder.sv
// -----------------------------------------------------------------------------
// tb_stepper_phase_decoder
//   Scoreboard bench. The driver issues one phase/rst pair per cycle and pushes
//   the expected outputs, which come from a coil-index reference model. A
//   separate monitor pops those outputs on each falling edge and compares them.
// -----------------------------------------------------------------------------
module tb_stepper_phase_decoder;

   localparam int POS_W = 8;
   localparam int SC    = 16;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [3:0]       phase = 4'b0000;
   logic [POS_W-1:0] pos;
   logic             dir, step_pulse, locked, err, stalled;

   always #5 clk = ~clk;

   stepper_phase_decoder #(.POS_W(POS_W), .STALL_CYCLES(SC)) dut (
      .clk(clk), .rst(rst), .phase(phase), .pos(pos), .dir(dir),
      .step_pulse(step_pulse), .locked(locked), .err(err), .stalled(stalled)
   );

   typedef struct packed {
      logic [POS_W-1:0] pos;
      logic dir, pulse, locked, err, stalled;
   } exp_t;

   exp_t sb_q[$];
   int   errors = 0;
   int   checks = 0;

   // Reference model. Coils are numbered 0..3 in forward order (1000 = 0).
   int         m_mode = 0;     // 0 idle, 1 locked, 2 fault
   int         m_prev = 0;
   int         m_pos  = 0;
   bit         m_dir  = 1'b1;
   bit         m_pulse = 1'b0;
   int         m_hold = 0;
   logic [3:0] m_q    = 4'b0000;
   logic [3:0] cur    = 4'b0000;  // phase currently driven

   function automatic int coil(input logic [3:0] p);
      logic [3:0] one;
      one = 4'b1000;
      for (int i = 0; i < 4; i++) if (p == (one >> i)) return i;
      return -1;
   endfunction

   function automatic logic [3:0] coil_bits(input int c);
      logic [3:0] one;
      one = 4'b1000;
      return one >> (c % 4);
   endfunction

   task automatic model_step(input logic [3:0] p, input bit r);
      int c;
      exp_t e;
      if (r) begin
         m_mode = 0; m_pos = 0; m_dir = 1'b1; m_pulse = 1'b0; m_hold = 0; m_q = 4'b0000;
      end else begin
         m_pulse = 1'b0;
         c = coil(m_q);
         case (m_mode)
            0: if (m_q != 4'b0000) begin
                  if (c >= 0) begin m_mode = 1; m_prev = c; m_hold = 0; end
                  else m_mode = 2;
               end
            1: begin
               if (m_q == 4'b0000) begin m_mode = 0; m_hold = 0; end
               else if (c == m_prev) begin if (m_hold < SC) m_hold++; end
               else if (c >= 0 && c == (m_prev + 1) % 4) begin
                  m_pos = (m_pos + 1) % 256; m_dir = 1'b1; m_pulse = 1'b1; m_prev = c; m_hold = 0;
               end else if (c >= 0 && c == (m_prev + 3) % 4) begin
                  m_pos = (m_pos + 255) % 256; m_dir = 1'b0; m_pulse = 1'b1; m_prev = c; m_hold = 0;
               end else begin m_mode = 2; m_hold = 0; end
            end
            default: if (m_q == 4'b0000) m_mode = 0;
         endcase
         m_q = p;
      end
      e.pos     = m_pos[POS_W-1:0];
      e.dir     = m_dir;
      e.pulse   = m_pulse;
      e.locked  = (m_mode == 1);
      e.err     = (m_mode == 2);
      e.stalled = (m_mode == 1) && (m_hold >= SC);
      sb_q.push_back(e);
   endtask

   // One clock: drive inputs, take the edge, update the model, then step off the edge.
   task automatic cycle(input logic [3:0] p, input bit r);
      phase = p;
      rst   = r;
      cur   = p;
      @(posedge clk);
      model_step(p, r);
      #1;
   endtask

   function automatic logic [3:0] next_fwd(input logic [3:0] p);
      int c;
      c = coil(p);
      return (c < 0) ? 4'b1000 : coil_bits(c + 1);
   endfunction

   function automatic logic [3:0] next_rev(input logic [3:0] p);
      int c;
      c = coil(p);
      return (c < 0) ? 4'b0001 : coil_bits(c + 3);
   endfunction

   // Monitor: the DUT presents a fresh output set every cycle.
   initial begin
      exp_t e, got;
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            got = {pos, dir, step_pulse, locked, err, stalled};
            checks++;
            if (got !== e) begin
               errors++;
               $display("FAIL outputs t=%0t got pos=%h dir=%b pulse=%b locked=%b err=%b stalled=%b exp pos=%h dir=%b pulse=%b locked=%b err=%b stalled=%b",
                        $time, got.pos, got.dir, got.pulse, got.locked, got.err, got.stalled,
                        e.pos, e.dir, e.pulse, e.locked, e.err, e.stalled);
            end
         end
      end
   end

   initial begin
      logic [3:0] seq[5];
      int r, n, guard;

      // Reset state.
      cycle(4'b0000, 1'b1);
      cycle(4'b0000, 1'b1);
      cycle(4'b0000, 1'b0);

      // Forward walk: lock, then four steps.
      seq = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};
      foreach (seq[i]) repeat (2) cycle(seq[i], 1'b0);
      cycle(4'b1000, 1'b0);

      // Reverse two steps from 0100.
      repeat (2) cycle(4'b0100, 1'b0);
      repeat (2) cycle(4'b1000, 1'b0);
      repeat (2) cycle(4'b0001, 1'b0);
      cycle(4'b0001, 1'b0);

      // Skipped step to the opposite coil, then recover through 0000.
      repeat (2) cycle(4'b1000, 1'b0);
      repeat (3) cycle(4'b0010, 1'b0);
      repeat (3) cycle(4'b0000, 1'b0);

      // Stall: hold one coil well past STALL_CYCLES, then step.
      repeat (SC + 6) cycle(4'b1000, 1'b0);
      repeat (3) cycle(4'b0100, 1'b0);

      // Walk forward to 0x7F, then wrap to 0x80.
      guard = 0;
      while (m_pos != 8'h7F && guard < 600) begin
         cycle(next_fwd(cur), 1'b0);
         guard++;
      end
      repeat (2) cycle(next_fwd(cur), 1'b0);

      // Reset on the same edge where a step would be decided.
      n = next_fwd(cur);
      cycle(n[3:0], 1'b0);
      cycle(n[3:0], 1'b1);
      repeat (2) cycle(4'b0000, 1'b0);

      // Random traffic.
      for (int k = 0; k < 2500; k++) begin
         r = $urandom_range(0, 99);
         if (r < 45)      cycle(next_fwd(cur), 1'b0);
         else if (r < 60) cycle(next_rev(cur), 1'b0);
         else if (r < 80) begin
            n = $urandom_range(1, SC + 4);
            repeat (n) cycle(cur, 1'b0);
         end
         else if (r < 90) cycle(4'b0000, 1'b0);
         else if (r < 97) cycle(4'($urandom_range(0, 15)), 1'b0);
         else             cycle(cur, 1'b1);
      end

      cycle(4'b0000, 1'b0);
      repeat (2) @(negedge clk);
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL drain leftover=%0d required=0", sb_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
